// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for pong: serve/rally/point/game-over control, scores,
// serving side, ball gating/re-centring and frame-timed beep requests.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned POINT_FRAMES = 60,
  parameter int unsigned BEEP_FRAMES  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       p1_srv,
  input  logic       p2_srv,
  input  logic       paddle_hit,
  input  logic       wall_bounce,
  input  logic       goal_l,
  input  logic       goal_r,
  output logic       ball_run,
  output logic       ball_recentre,
  output logic       serve_dir,
  output logic       server,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner,
  output logic       beep_low,
  output logic       beep_high
);

  // A zero-length point hold still waits for one frame.
  localparam int unsigned PointLoad = (POINT_FRAMES == 0) ? 1 : POINT_FRAMES;
  localparam int unsigned PcW       = $clog2(PointLoad + 1);
  localparam int unsigned BcW       = $clog2(BEEP_FRAMES + 2);

  localparam logic [3:0]     WinScore   = 4'(WIN_SCORE);
  localparam logic [PcW-1:0] PointLoadV = PcW'(PointLoad);
  localparam logic [BcW-1:0] BeepLoadV  = BcW'(BEEP_FRAMES);
  localparam logic           BeepOn     = (BEEP_FRAMES != 0);

  localparam logic [1:0] StServe    = 2'd0;
  localparam logic [1:0] StRally    = 2'd1;
  localparam logic [1:0] StPoint    = 2'd2;
  localparam logic [1:0] StGameOver = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [5:0]     hist_q;
  logic [5:0]     in_now, rise;
  logic           ball_run_q, ball_run_d;
  logic           recentre_q, recentre_d;
  logic           serve_dir_q, serve_dir_d;
  logic           server_q, server_d;
  logic [3:0]     score1_q, score1_d;
  logic [3:0]     score2_q, score2_d;
  logic           game_over_q, game_over_d;
  logic           winner_q, winner_d;
  logic           beep_low_q, beep_low_d;
  logic           beep_high_q, beep_high_d;
  logic [PcW-1:0] point_cnt_q, point_cnt_d;
  logic [BcW-1:0] beep_cnt_q, beep_cnt_d;
  logic           goal_evt, low_evt;

  // Bit order: {goal_r, goal_l, wall_bounce, paddle_hit, p2_srv, p1_srv}
  assign in_now = {goal_r, goal_l, wall_bounce, paddle_hit, p2_srv, p1_srv};
  assign rise   = in_now & ~hist_q;

  // Next-state: match FSM, scoring and the shared beep timer
  always_comb begin
    state_d     = state_q;
    ball_run_d  = ball_run_q;
    recentre_d  = 1'b0;
    serve_dir_d = serve_dir_q;
    server_d    = server_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    point_cnt_d = point_cnt_q;
    beep_low_d  = beep_low_q;
    beep_high_d = beep_high_q;
    beep_cnt_d  = beep_cnt_q;
    goal_evt    = 1'b0;
    low_evt     = 1'b0;

    unique case (state_q)
      StServe: begin
        // Only the current server's button launches the ball.
        if ((!server_q && rise[0]) || (server_q && rise[1])) begin
          state_d     = StRally;
          ball_run_d  = 1'b1;
          serve_dir_d = ~server_q;
        end
      end
      StRally: begin
        // goal_l wins a tie with goal_r.
        if (rise[4]) begin
          goal_evt = 1'b1;
          server_d = 1'b0;
          if (score2_q < WinScore) score2_d = score2_q + 4'd1;
        end else if (rise[5]) begin
          goal_evt = 1'b1;
          server_d = 1'b1;
          if (score1_q < WinScore) score1_d = score1_q + 4'd1;
        end
        if (goal_evt) begin
          ball_run_d  = 1'b0;
          recentre_d  = 1'b1;
          point_cnt_d = PointLoadV;
          if ((score1_d == WinScore) || (score2_d == WinScore)) begin
            state_d     = StGameOver;
            game_over_d = 1'b1;
            winner_d    = (score1_d != WinScore);
          end else begin
            state_d = StPoint;
          end
        end else if (rise[2] || rise[3]) begin
          low_evt = 1'b1;
        end
      end
      StPoint: begin
        if (frame_tick) begin
          if (point_cnt_q <= PcW'(1)) begin
            state_d     = StServe;
            point_cnt_d = '0;
          end else begin
            point_cnt_d = point_cnt_q - PcW'(1);
          end
        end
      end
      StGameOver: begin
        // Server is left as the loser of the final point.
        if (rise[0] || rise[1]) begin
          state_d     = StServe;
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          game_over_d = 1'b0;
        end
      end
      default: state_d = StServe;
    endcase

    // A fresh event reloads the timer and swallows a same-cycle tick.
    if (goal_evt) begin
      beep_cnt_d  = BeepLoadV;
      beep_high_d = BeepOn;
      beep_low_d  = 1'b0;
    end else if (low_evt && !beep_high_q) begin
      beep_cnt_d  = BeepLoadV;
      beep_low_d  = BeepOn;
      beep_high_d = 1'b0;
    end else if (frame_tick && (beep_cnt_q != '0)) begin
      beep_cnt_d = beep_cnt_q - BcW'(1);
      if (beep_cnt_q == BcW'(1)) begin
        beep_low_d  = 1'b0;
        beep_high_d = 1'b0;
      end
    end
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StServe;
      hist_q      <= '0;
      ball_run_q  <= 1'b0;
      recentre_q  <= 1'b0;
      serve_dir_q <= 1'b0;
      server_q    <= 1'b1;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      beep_low_q  <= 1'b0;
      beep_high_q <= 1'b0;
      point_cnt_q <= '0;
      beep_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= in_now;
      ball_run_q  <= ball_run_d;
      recentre_q  <= recentre_d;
      serve_dir_q <= serve_dir_d;
      server_q    <= server_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      beep_low_q  <= beep_low_d;
      beep_high_q <= beep_high_d;
      point_cnt_q <= point_cnt_d;
      beep_cnt_q  <= beep_cnt_d;
    end
  end

  assign ball_run      = ball_run_q;
  assign ball_recentre = recentre_q;
  assign serve_dir     = serve_dir_q;
  assign server        = server_q;
  assign score1        = score1_q;
  assign score2        = score2_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;
  assign beep_low      = beep_low_q;
  assign beep_high     = beep_high_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match scenarios plus a randomized run
// checked cycle-by-cycle against a rule-level reference model.
module tb_pong_match_ctrl;
  localparam int WIN = 9;
  localparam int PF  = 60;
  localparam int BF  = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       p1_srv = 1'b0, p2_srv = 1'b0;
  logic       paddle_hit = 1'b0, wall_bounce = 1'b0;
  logic       goal_l = 1'b0, goal_r = 1'b0;
  logic       ball_run, ball_recentre, serve_dir, server;
  logic [3:0] score1, score2;
  logic       game_over, winner, beep_low, beep_high;

  int n_vec = 0;
  int n_err = 0;

  pong_match_ctrl #(
    .WIN_SCORE   (WIN),
    .POINT_FRAMES(PF),
    .BEEP_FRAMES (BF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .p1_srv       (p1_srv),
    .p2_srv       (p2_srv),
    .paddle_hit   (paddle_hit),
    .wall_bounce  (wall_bounce),
    .goal_l       (goal_l),
    .goal_r       (goal_r),
    .ball_run     (ball_run),
    .ball_recentre(ball_recentre),
    .serve_dir    (serve_dir),
    .server       (server),
    .score1       (score1),
    .score2       (score2),
    .game_over    (game_over),
    .winner       (winner),
    .beep_low     (beep_low),
    .beep_high    (beep_high)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 serve, 1 rally, 2 point, 3 game over.
  int m_phase, m_s1, m_s2, m_frames_left, m_beep_left, m_tone;
  bit m_run, m_recentre, m_dir, m_server, m_over, m_winner;
  bit h_s1, h_s2, h_ph, h_wb, h_gl, h_gr;

  task automatic model_reset();
    m_phase = 0; m_s1 = 0; m_s2 = 0; m_frames_left = 0; m_beep_left = 0; m_tone = 0;
    m_run = 0; m_recentre = 0; m_dir = 0; m_server = 1; m_over = 0; m_winner = 0;
    h_s1 = 0; h_s2 = 0; h_ph = 0; h_wb = 0; h_gl = 0; h_gr = 0;
  endtask

  task automatic model_step();
    bit r_s1, r_s2, r_ph, r_wb, r_gl, r_gr, goal, low;
    r_s1 = p1_srv && !h_s1;      r_s2 = p2_srv && !h_s2;
    r_ph = paddle_hit && !h_ph;  r_wb = wall_bounce && !h_wb;
    r_gl = goal_l && !h_gl;      r_gr = goal_r && !h_gr;
    goal = 0; low = 0; m_recentre = 0;
    case (m_phase)
      0: if ((m_server == 0 && r_s1) || (m_server == 1 && r_s2)) begin
        m_phase = 1; m_run = 1; m_dir = (m_server == 0);
      end
      1: begin
        if (r_gl) begin
          goal = 1; m_server = 0; if (m_s2 < WIN) m_s2++;
        end else if (r_gr) begin
          goal = 1; m_server = 1; if (m_s1 < WIN) m_s1++;
        end
        if (goal) begin
          m_run = 0; m_recentre = 1; m_frames_left = (PF == 0) ? 1 : PF;
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_phase = 3; m_over = 1; m_winner = (m_s1 == WIN) ? 0 : 1;
          end else m_phase = 2;
        end else low = r_ph || r_wb;
      end
      2: if (frame_tick) begin
        m_frames_left--;
        if (m_frames_left == 0) m_phase = 0;
      end
      default: if (r_s1 || r_s2) begin
        m_s1 = 0; m_s2 = 0; m_over = 0; m_phase = 0;
      end
    endcase
    if (goal) begin
      m_tone = 2; m_beep_left = BF;
    end else if (low && m_tone != 2) begin
      m_tone = 1; m_beep_left = BF;
    end else if (frame_tick && m_beep_left > 0) begin
      m_beep_left--;
    end
    if (m_beep_left == 0) m_tone = 0;
    h_s1 = p1_srv; h_s2 = p2_srv; h_ph = paddle_hit;
    h_wb = wall_bounce; h_gl = goal_l; h_gr = goal_r;
  endtask

  // One clock: model follows the same edge, outputs sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic tick_frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc();
    end
  endtask

  task automatic pulse_p1();
    p1_srv = 1'b1; cyc(); p1_srv = 1'b0; cyc();
  endtask

  task automatic pulse_p2();
    p2_srv = 1'b1; cyc(); p2_srv = 1'b0; cyc();
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ball_run, ball_recentre, serve_dir, server, score1, score2, game_over, winner,
         beep_low, beep_high} !== 16'b0001_0000_0000_0000) begin
      n_err++;
      $display("FAIL reset_values: got run=%b rc=%b dir=%b srv=%b s1=%0d s2=%0d go=%b w=%b bl=%b bh=%b, expected srv=1 all else 0",
               ball_run, ball_recentre, serve_dir, server, score1, score2, game_over,
               winner, beep_low, beep_high);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_serve();
    pulse_p1();
    n_vec++;
    if (ball_run !== 1'b0) begin
      n_err++; $display("FAIL serve_wrong_player: ball_run=%b expected 0", ball_run);
    end
    p2_srv = 1'b1; cyc();
    n_vec++;
    if ({ball_run, serve_dir} !== 2'b10) begin
      n_err++; $display("FAIL serve_p2: run/dir=%b%b expected 10", ball_run, serve_dir);
    end
    p2_srv = 1'b0; cyc();
  endtask

  task automatic test_goal();
    int rc;
    rc = 0;
    goal_r = 1'b1;
    cyc();
    rc += int'(ball_recentre);
    n_vec++;
    if ({score1, server, beep_high, beep_low, ball_run} !== {4'd1, 4'b1100}) begin
      n_err++;
      $display("FAIL goal_r_first: s1=%0d srv=%b bh=%b bl=%b run=%b expected 1 1 1 0 0",
               score1, server, beep_high, beep_low, ball_run);
    end
    repeat (4) begin cyc(); rc += int'(ball_recentre); end
    goal_r = 1'b0; cyc(); rc += int'(ball_recentre);
    n_vec++;
    if (rc != 1 || score1 !== 4'd1) begin
      n_err++; $display("FAIL goal_r_held: recentre cycles=%0d s1=%0d expected 1 and 1", rc, score1);
    end
    tick_frames(5);
    n_vec++;
    if (beep_high !== 1'b1) begin
      n_err++; $display("FAIL beep_high_5: bh=%b expected 1", beep_high);
    end
    tick_frames(1);
    n_vec++;
    if (beep_high !== 1'b0) begin
      n_err++; $display("FAIL beep_high_6: bh=%b expected 0", beep_high);
    end
    tick_frames(PF - 7);
    pulse_p2();
    n_vec++;
    if (ball_run !== 1'b0) begin
      n_err++; $display("FAIL point_early_serve: ball_run=%b expected 0 at 59 frames", ball_run);
    end
    tick_frames(1);
    pulse_p2();
    n_vec++;
    if ({ball_run, serve_dir} !== 2'b10) begin
      n_err++; $display("FAIL point_serve_60: run/dir=%b%b expected 10", ball_run, serve_dir);
    end
  endtask

  task automatic test_beep_priority();
    goal_r = 1'b1; cyc(); goal_r = 1'b0; cyc();
    tick_frames(2);
    paddle_hit = 1'b1; cyc(); paddle_hit = 1'b0; cyc();
    n_vec++;
    if ({beep_high, beep_low} !== 2'b10) begin
      n_err++; $display("FAIL paddle_during_high: bh/bl=%b%b expected 10", beep_high, beep_low);
    end
    tick_frames(3);
    n_vec++;
    if ({beep_high, beep_low, score1} !== {2'b10, 4'd2}) begin
      n_err++;
      $display("FAIL high_continues: bh/bl=%b%b s1=%0d expected 10 s1=2", beep_high, beep_low, score1);
    end
    tick_frames(PF - 5);
    pulse_p2();
    wall_bounce = 1'b1; cyc();
    n_vec++;
    if ({ball_run, beep_low, beep_high} !== 3'b110) begin
      n_err++;
      $display("FAIL wall_low_start: run/bl/bh=%b%b%b expected 110", ball_run, beep_low, beep_high);
    end
    wall_bounce = 1'b0; cyc();
    tick_frames(5);
    n_vec++;
    if (beep_low !== 1'b1) begin
      n_err++; $display("FAIL beep_low_5: bl=%b expected 1", beep_low);
    end
    tick_frames(1);
    n_vec++;
    if (beep_low !== 1'b0) begin
      n_err++; $display("FAIL beep_low_6: bl=%b expected 0", beep_low);
    end
  endtask

  task automatic test_simultaneous_goals();
    goal_l = 1'b1; goal_r = 1'b1; cyc();
    n_vec++;
    if ({score1, score2, server} !== {4'd2, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL both_goals: s1=%0d s2=%0d srv=%b expected 2 1 0", score1, score2, server);
    end
    goal_l = 1'b0; goal_r = 1'b0; cyc();
    tick_frames(PF);
    pulse_p1();
    n_vec++;
    if ({ball_run, serve_dir} !== 2'b11) begin
      n_err++; $display("FAIL serve_p1: run/dir=%b%b expected 11", ball_run, serve_dir);
    end
  endtask

  task automatic test_game_over();
    int s1;
    s1 = 2;
    while (s1 < WIN - 1) begin
      goal_r = 1'b1; cyc(); goal_r = 1'b0; cyc();
      s1++;
      tick_frames(PF);
      pulse_p2();
    end
    n_vec++;
    if ({score1, ball_run} !== {4'(WIN - 1), 1'b1}) begin
      n_err++; $display("FAIL reach_8: s1=%0d run=%b expected 8 1", score1, ball_run);
    end
    goal_r = 1'b1; cyc();
    n_vec++;
    if ({score1, score2, game_over, winner, ball_run} !== {4'(WIN), 4'd1, 3'b100}) begin
      n_err++;
      $display("FAIL win: s1=%0d s2=%0d go=%b w=%b run=%b expected 9 1 1 0 0",
               score1, score2, game_over, winner, ball_run);
    end
    goal_r = 1'b0; cyc();
    goal_r = 1'b1; cyc(); goal_r = 1'b0; cyc();
    n_vec++;
    if ({score1, game_over} !== {4'(WIN), 1'b1}) begin
      n_err++; $display("FAIL frozen: s1=%0d go=%b expected 9 1", score1, game_over);
    end
    pulse_p2();
    n_vec++;
    if ({score1, score2, game_over, server, ball_run} !== {8'd0, 3'b010}) begin
      n_err++;
      $display("FAIL restart: s1=%0d s2=%0d go=%b srv=%b run=%b expected 0 0 0 1 0",
               score1, score2, game_over, server, ball_run);
    end
    pulse_p2();
    n_vec++;
    if ({ball_run, serve_dir} !== 2'b10) begin
      n_err++; $display("FAIL restart_serve: run/dir=%b%b expected 10", ball_run, serve_dir);
    end
  endtask

  task automatic test_reset_mid_point();
    goal_l = 1'b1; cyc(); goal_l = 1'b0; cyc();
    tick_frames(2);
    n_vec++;
    if ({score2, beep_high} !== {4'd1, 1'b1}) begin
      n_err++; $display("FAIL pre_reset: s2=%0d bh=%b expected 1 1", score2, beep_high);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({ball_run, ball_recentre, serve_dir, server, score1, score2, game_over, winner,
         beep_low, beep_high} !== 16'b0001_0000_0000_0000) begin
      n_err++;
      $display("FAIL async_reset: run=%b srv=%b s1=%0d s2=%0d go=%b bl=%b bh=%b expected srv=1 all else 0",
               ball_run, server, score1, score2, game_over, beep_low, beep_high);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();
    pulse_p2();
    n_vec++;
    if ({ball_run, serve_dir, score2} !== {2'b10, 4'd0}) begin
      n_err++;
      $display("FAIL post_reset_serve: run/dir=%b%b s2=%0d expected 10 0", ball_run, serve_dir, score2);
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    for (int i = 0; i < 20000; i++) begin
      frame_tick = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0)  p1_srv      = ~p1_srv;
      if ($urandom_range(7) == 0)  p2_srv      = ~p2_srv;
      if ($urandom_range(5) == 0)  paddle_hit  = ~paddle_hit;
      if ($urandom_range(5) == 0)  wall_bounce = ~wall_bounce;
      if ($urandom_range(31) == 0) goal_l      = ~goal_l;
      if ($urandom_range(31) == 0) goal_r      = ~goal_r;
      cyc();
      got = {ball_run, ball_recentre, serve_dir, server, score1, score2, game_over, winner,
             beep_low, beep_high};
      exp = {m_run, m_recentre, m_dir, m_server, 4'(m_s1), 4'(m_s2), m_over, m_winner,
             m_tone == 1, m_tone == 2};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        if (n_err <= 10)
          $display("FAIL random cycle %0d: outputs=%h expected %h", i, got, exp);
      end
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve();
    test_goal();
    test_beep_priority();
    test_simultaneous_goals();
    test_game_over();
    test_reset_mid_point();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
